ysyx_22041207_ifu_prefetch: RTL

Parametrised instruction-fetch unit for the ysyx_22041207 RV64 pipeline. It issues in-order read requests on the AXI-style instruction port, keeping several reads outstanding, and queues returned instructions in a prefetch buffer. It presents instructions to decode through a valid/ready handshake. Control-flow and trap redirects flush the buffer and discard stale responses that are still in flight.

---
 rtl/ysyx_22041207_pkg.sv | 21 ++
 rtl/ysyx_22041207_sync_fifo.sv | 66 ++++++
 rtl/ysyx_22041207_ifu_prefetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_pkg.sv
// Shared types and constants for the ysyx_22041207 instruction fetch unit.
package ysyx_22041207_pkg;

   localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
   localparam logic [7:0]  AR_SIZE_WORD = 8'b0000_1111;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } inst_entry_t;

   typedef struct packed {
      logic        stale;
      logic [63:0] pc;
   } tag_t;

   function automatic logic [63:0] align4(input logic [63:0] a);
      return {a[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_22041207_sync_fifo.sv
// Small synchronous FIFO with flush; used for the tag queue and the
// instruction buffer of the fetch unit.
module ysyx_22041207_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_q];
   assign count   = cnt_q;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = inc(wr_q);
         if (do_pop)  rd_d = inc(rd_q);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (do_push && !flush) mem_q[wr_q] <= wdata;
      end
   end

endmodule

// File: rtl/ysyx_22041207_ifu_prefetch.sv
// Prefetching instruction fetch unit with in-order outstanding reads.
// Define YSYX_22041207_IFU_BYPASS_EN for a 0-cycle response bypass.
module ysyx_22041207_ifu_prefetch
   import ysyx_22041207_pkg::*;
#(
   parameter logic [63:0] RESET_PC        = RESET_PC_DEF,
   parameter int          BUF_DEPTH       = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid_i,
   input  logic [63:0] redirect_pc_i,
   input  logic        trap_valid_i,
   input  logic [63:0] csr_mtvec_i,
   output logic        ar_valid_o,
   input  logic        ar_ready_i,
   output logic [63:0] ar_addr_o,
   output logic [7:0]  ar_size_o,
   input  logic        r_valid_i,
   output logic        r_ready_o,
   input  logic [63:0] r_data_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [63:0] pc_o
);

   localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int BCW = $clog2(BUF_DEPTH + 1);

   logic [63:0] pc_q, pc_d, ar_addr_q, ar_addr_d, target;
   logic        ar_valid_q, ar_valid_d, ar_stale_q, ar_stale_d;
   logic [MAX_OUTSTANDING-1:0] stale_q, stale_d;

   logic           redir, ar_hs, resp, resp_keep, can_issue;
   tag_t           tag_w, tag_r;
   logic [TCW-1:0] tag_count, tag_nxt, push_idx;
   logic           tag_full, tag_empty;
   inst_entry_t    resp_entry, buf_r, out_entry;
   logic [BCW-1:0] buf_count, buf_nxt;
   logic           buf_full, buf_empty, buf_push, buf_pop, out_valid;
   logic [31:0]    word;

   assign redir  = redirect_valid_i || trap_valid_i;
   assign target = redirect_valid_i ? align4(redirect_pc_i)
                                    : align4(csr_mtvec_i);
   assign ar_hs  = ar_valid_q && ar_ready_i;
   assign resp   = r_valid_i && !tag_empty;

   assign tag_w.stale = ar_stale_q || redir;
   assign tag_w.pc    = ar_addr_q;

   ysyx_22041207_sync_fifo #(
      .WIDTH($bits(tag_t)),
      .DEPTH(MAX_OUTSTANDING)
   ) u_tag_q (
      .clk  (clk),
      .rst_n(rst_n),
      .push (ar_hs),
      .pop  (r_valid_i),
      .flush(1'b0),
      .wdata(tag_w),
      .rdata(tag_r),
      .count(tag_count),
      .full (tag_full),
      .empty(tag_empty)
   );

   // A redirect in the response cycle kills that response too.
   assign word = tag_r.pc[2] ? r_data_i[63:32] : r_data_i[31:0];
   assign resp_keep = resp && !(tag_r.stale || stale_q[0] || redir);
   assign resp_entry.pc   = tag_r.pc;
   assign resp_entry.inst = word;
   assign buf_pop = !buf_empty && inst_ready_i;

`ifdef YSYX_22041207_IFU_BYPASS_EN
   logic byp;
   assign byp       = resp_keep && buf_empty;
   assign buf_push  = resp_keep && !(byp && inst_ready_i);
   assign out_valid = !buf_empty || byp;
   assign out_entry = buf_empty ? resp_entry : buf_r;
`else
   assign buf_push  = resp_keep;
   assign out_valid = !buf_empty;
   assign out_entry = buf_r;
`endif

   ysyx_22041207_sync_fifo #(
      .WIDTH($bits(inst_entry_t)),
      .DEPTH(BUF_DEPTH)
   ) u_buf (
      .clk  (clk),
      .rst_n(rst_n),
      .push (buf_push),
      .pop  (buf_pop),
      .flush(redir),
      .wdata(resp_entry),
      .rdata(buf_r),
      .count(buf_count),
      .full (buf_full),
      .empty(buf_empty)
   );

   // Credit counts every read in flight as an already-reserved buffer slot.
   assign tag_nxt   = tag_count + TCW'(ar_hs) - TCW'(resp);
   assign buf_nxt   = redir ? '0
                            : buf_count + BCW'(buf_push) - BCW'(buf_pop);
   assign can_issue = (int'(buf_nxt) + int'(tag_nxt) < BUF_DEPTH)
                   && (int'(tag_nxt) < MAX_OUTSTANDING);
   assign push_idx  = tag_count - TCW'(resp);

   always_comb begin
      pc_d       = pc_q;
      ar_valid_d = ar_valid_q;
      ar_addr_d  = ar_addr_q;
      ar_stale_d = ar_stale_q;
      stale_d    = stale_q;
      if (ar_hs) begin
         ar_stale_d = 1'b0;
         if (!ar_stale_q) pc_d = pc_q + 64'd4;
      end
      if (redir) begin
         pc_d = target;
         if (ar_valid_q && !ar_ready_i) ar_stale_d = 1'b1;
      end
      if (!ar_valid_q || ar_ready_i) begin
         ar_valid_d = can_issue;
         if (can_issue) ar_addr_d = pc_d;
      end
      if (resp) stale_d = stale_q >> 1;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (ar_hs && TCW'(i) == push_idx) stale_d[i] = tag_w.stale;
      end
      if (redir) stale_d = '1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         ar_valid_q <= 1'b0;
         ar_addr_q  <= '0;
         ar_stale_q <= 1'b0;
         stale_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         ar_valid_q <= ar_valid_d;
         ar_addr_q  <= ar_addr_d;
         ar_stale_q <= ar_stale_d;
         stale_q    <= stale_d;
      end
   end

   assign ar_valid_o   = ar_valid_q;
   assign ar_addr_o    = ar_addr_q;
   assign ar_size_o    = AR_SIZE_WORD;
   assign r_ready_o    = 1'b1;
   assign inst_valid_o = out_valid;
   assign inst_o       = out_valid ? out_entry.inst : 32'd0;
   assign pc_o         = out_valid ? out_entry.pc : 64'd0;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && r_valid_i && tag_empty)
         $error("ifu: read response with no outstanding request");
      if (rst_n && ar_hs && tag_full && !resp)
         $error("ifu: tag queue overflow");
      if (rst_n && buf_push && buf_full && !buf_pop && !redir)
         $error("ifu: instruction buffer overflow");
   end
`endif

endmodule
